// File: rtl/onehot_ring_counter_pkg.sv
// onehot_ring_counter_pkg: shared sizing and index-to-one-hot helpers
package onehot_ring_counter_pkg;
  localparam int MAX_N = 1024;
  function automatic int calc_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction
  // Wide result; callers truncate to their own N
  function automatic logic [MAX_N-1:0] idx2oh(input int unsigned idx);
    return MAX_N'(1) << idx;
  endfunction
endpackage

// File: rtl/onehot_ring_counter_if.sv
// onehot_ring_counter_if: control inputs and state outputs of the ring counter
interface onehot_ring_counter_if
  import onehot_ring_counter_pkg::*;
#(
  parameter int N = 16
) ();
  localparam int W = calc_w(N);
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_idx;
  logic [N-1:0] q;
  logic [W-1:0] c;
  logic         wrap;
  logic         err;
  modport master (output en, dir, load, load_idx, input q, c, wrap, err);
  modport slave (input en, dir, load, load_idx, output q, c, wrap, err);
endinterface

// File: rtl/onehot_ring_counter_encoder.sv
// onehot_encoder: N-input one-hot to W-bit binary OR-plane encoder
module onehot_encoder
  import onehot_ring_counter_pkg::*;
#(
  parameter int N = 16,
  localparam int W = calc_w(N)
) (
  input  logic [N-1:0] oh_i,
  output logic [W-1:0] bin_o
);
  always_comb begin
    bin_o = '0;
    for (int i = 0; i < N; i++) bin_o = bin_o | (oh_i[i] ? W'(i) : '0);
  end
endmodule

// File: rtl/onehot_ring_counter.sv
// onehot_ring_counter: N-stage one-hot ring with load, direction, wrap pulse and self-repair
module onehot_ring_counter
  import onehot_ring_counter_pkg::*;
#(
  parameter int N = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  onehot_ring_counter_if.slave  bus
);
  logic [N-1:0] q_q, q_d, rot_up, rot_dn;
  logic         wrap_q, wrap_d, err_q, err_d;
  logic         legal, ld_ok;
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero
  assign legal  = (q_q != '0) && ((q_q & (q_q - N'(1))) == '0);
  assign ld_ok  = 32'(bus.load_idx) < 32'(N);
  assign rot_up = {q_q[N-2:0], q_q[N-1]};
  assign rot_dn = {q_q[0], q_q[N-1:1]};
  always_comb begin
    q_d    = !legal ? N'(1)
           : bus.load ? (ld_ok ? N'(idx2oh(32'(bus.load_idx))) : q_q)
           : bus.en ? (bus.dir ? rot_up : rot_dn)
           : q_q;
    wrap_d = legal && !bus.load && bus.en && (bus.dir ? q_q[N-1] : q_q[0]);
    err_d  = !legal || (bus.load && !ld_ok);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q    <= N'(1);
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign bus.q    = q_q;
  assign bus.wrap = wrap_q;
  assign bus.err  = err_q;
  onehot_encoder #(.N(N)) u_enc (.oh_i(q_q), .bin_o(bus.c));
endmodule

// File: tb/tb_onehot_ring_counter.sv
// tb_onehot_ring_counter: directed vector table plus reset/repair sequences for N=16 and N=12
module tb_onehot_ring_counter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;

  onehot_ring_counter_if #(.N(16)) b16 ();
  onehot_ring_counter_if #(.N(12)) b12 ();
  onehot_ring_counter #(.N(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
  onehot_ring_counter #(.N(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

  typedef struct {
    bit       sel;
    bit       load;
    logic [3:0] idx;
    bit       en;
    bit       dir;
    int       c;
    bit       wrap;
    bit       err;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(bit sel, bit load, int idx, bit en, bit dir, int c, bit wrap, bit err);
    vec_t v;
    v.sel = sel; v.load = load; v.idx = 4'(idx); v.en = en; v.dir = dir;
    v.c = c; v.wrap = wrap; v.err = err;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    b16.load = !v.sel && v.load; b16.load_idx = v.idx; b16.en = !v.sel && v.en; b16.dir = v.dir;
    b12.load = v.sel && v.load;  b12.load_idx = v.idx; b12.en = v.sel && v.en;  b12.dir = v.dir;
  endtask

  task automatic idle();
    b16.load = 0; b16.en = 0; b16.dir = 0; b16.load_idx = 0;
    b12.load = 0; b12.en = 0; b12.dir = 0; b12.load_idx = 0;
  endtask

  task automatic check16(input string name, input int c, input bit wrap, input bit err);
    check({name, ".q"}, 32'(b16.q), 32'(1) << c);
    check({name, ".c"}, 32'(b16.c), 32'(c));
    check({name, ".wrap"}, 32'(b16.wrap), 32'(wrap));
    check({name, ".err"}, 32'(b16.err), 32'(err));
  endtask

  task automatic check12(input string name, input int c, input bit wrap, input bit err);
    check({name, ".q"}, 32'(b12.q), 32'(1) << c);
    check({name, ".c"}, 32'(b12.c), 32'(c));
    check({name, ".wrap"}, 32'(b12.wrap), 32'(wrap));
    check({name, ".err"}, 32'(b12.err), 32'(err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // up walk from reset: after k steps the index is k mod 16, wrapping on step 16
    for (int k = 1; k <= 20; k++) vecs.push_back(mk(0, 0, 0, 1, 1, k % 16, k == 16, 0));
    vecs.push_back(mk(0, 1, 2, 0, 0, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 15, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 14, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 15, 0, 0));
    for (int k = 0; k < 5; k++) vecs.push_back(mk(0, 0, 0, 0, 1, 15, 0, 0));
    vecs.push_back(mk(0, 1, 9, 1, 1, 9, 0, 0));
    vecs.push_back(mk(0, 1, 14, 0, 0, 14, 0, 0));
    vecs.push_back(mk(0, 1, 15, 1, 1, 15, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 15, 1, 0));
    vecs.push_back(mk(1, 1, 4, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, 1, 13, 1, 1, 4, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 4, 0, 0));
    vecs.push_back(mk(1, 1, 11, 0, 0, 11, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 11, 1, 0));
    vecs.push_back(mk(1, 1, 15, 1, 0, 11, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 0, 10, 0, 0));

    idle();
    repeat (2) @(negedge clk);
    check16("reset16", 0, 0, 0);
    check12("reset12", 0, 0, 0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i]);
      @(posedge clk);
      #1;
      if (vecs[i].sel) check12($sformatf("vec%0d", i), vecs[i].c, vecs[i].wrap, vecs[i].err);
      else check16($sformatf("vec%0d", i), vecs[i].c, vecs[i].wrap, vecs[i].err);
    end

    // repair of a multi-bit state wins over a simultaneous load
    @(negedge clk);
    idle();
    b16.load = 1; b16.load_idx = 5; b16.en = 1; b16.dir = 1;
    force u16.q_q = 16'h0088;
    #1 release u16.q_q;
    @(posedge clk);
    #1;
    check16("repair_multi", 0, 0, 1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check16("repair_multi_after", 0, 0, 0);

    // repair of the all-zero state
    @(negedge clk);
    b16.load = 1; b16.load_idx = 9;
    force u16.q_q = 16'h0000;
    #1 release u16.q_q;
    @(posedge clk);
    #1;
    check16("repair_zero", 0, 0, 1);
    @(negedge clk);
    idle();
    @(posedge clk);
    #1;
    check16("repair_zero_after", 0, 0, 0);

    // asynchronous reset between edges while counting; N=12 side holds a live ERR pulse
    @(negedge clk);
    b16.load = 1; b16.load_idx = 7;
    b12.load = 1; b12.load_idx = 13;
    @(posedge clk);
    #1;
    check16("pre_rst16", 7, 0, 0);
    check12("pre_rst12", 10, 0, 1);
    @(negedge clk);
    idle();
    b16.en = 1; b16.dir = 1;
    #2 rst_n = 1'b0;
    #1;
    check16("async_rst16", 0, 0, 0);
    check12("async_rst12", 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check16("resume", 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
